// File: rtl/pio_pkg.sv
// Shared definitions for the PIO irq servicer: slave register map and FSM states.
package pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CLR,
    RD_ISSUE,
    RD_CAP,
    OUT
  } state_e;

endpackage

// File: rtl/pio_irq_servicer.sv
// Avalon-MM initiator that arms an edge-capture PIO, services its irq and
// emits timestamped pin-level events on a valid/ready stream.
module pio_irq_servicer
  import pio_pkg::*;
#(
  parameter int          TS_W       = 16,
  parameter logic [31:0] MASK_VALUE = 32'd1,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             irq,
  output logic [1:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_level,
  output logic [TS_W-1:0]  evt_time,
  output logic [CNT_W-1:0] evt_count
);

  state_e           state_q, state_d;
  logic [1:0]       address_q, address_d;
  logic             cs_q, cs_d;
  logic             write_n_q, write_n_d;
  logic             wdata_q, wdata_d;
  logic             evt_valid_q, evt_valid_d;
  logic             evt_level_q, evt_level_d;
  logic [TS_W-1:0]  evt_time_q, evt_time_d;
  logic [CNT_W-1:0] evt_count_q, evt_count_d;
  logic [TS_W-1:0]  ts_q, ts_d;

  logic unused_readdata;
  assign unused_readdata = ^readdata[31:1];

  // Bus outputs are computed for the state being entered, so the registered
  // values line up with the state they belong to.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    address_d   = PIO_ADDR_DATA;
    cs_d        = 1'b0;
    write_n_d   = 1'b1;
    wdata_d     = 1'b0;
    evt_valid_d = evt_valid_q;
    evt_level_d = evt_level_q;
    evt_time_d  = evt_time_q;
    evt_count_d = evt_count_q;
    ts_d        = ts_q + TS_W'(1);

    unique case (state_q)
      INIT: begin
        // Reset leaves the bus idle; the mask write is shown for one cycle.
        if (cs_q) begin
          state_d = IDLE;
        end else begin
          cs_d      = 1'b1;
          write_n_d = 1'b0;
          address_d = PIO_ADDR_MASK;
          wdata_d   = MASK_VALUE[0];
        end
      end
      IDLE: begin
        if (irq && enable) begin
          evt_time_d = ts_q;
          state_d    = CLR;
          cs_d       = 1'b1;
          write_n_d  = 1'b0;
          address_d  = PIO_ADDR_EDGE;
        end
      end
      CLR: begin
        state_d = RD_ISSUE;
        cs_d    = 1'b1;
      end
      RD_ISSUE: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        evt_level_d = readdata[0];
        evt_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          state_d     = IDLE;
          if (evt_count_q != '1) evt_count_d = evt_count_q + CNT_W'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      address_q   <= PIO_ADDR_DATA;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      wdata_q     <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_level_q <= 1'b0;
      evt_time_q  <= '0;
      evt_count_q <= '0;
      ts_q        <= '0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      cs_q        <= cs_d;
      write_n_q   <= write_n_d;
      wdata_q     <= wdata_d;
      evt_valid_q <= evt_valid_d;
      evt_level_q <= evt_level_d;
      evt_time_q  <= evt_time_d;
      evt_count_q <= evt_count_d;
      ts_q        <= ts_d;
    end
  end

  assign address    = address_q;
  assign chipselect = cs_q;
  assign write_n    = write_n_q;
  assign writedata  = {31'b0, wdata_q};
  assign evt_valid  = evt_valid_q;
  assign evt_level  = evt_level_q;
  assign evt_time   = evt_time_q;
  assign evt_count  = evt_count_q;

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Self-checking bench: PIO slave model, transaction-level reference model and
// scoreboard monitor for pio_irq_servicer.
module tb_pio_irq_servicer;

  localparam int TS_W  = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             irq = 1'b0;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata = 32'd0;
  logic             evt_valid;
  logic             evt_ready = 1'b1;
  logic             evt_level;
  logic [TS_W-1:0]  evt_time;
  logic [CNT_W-1:0] evt_count;
  logic             pin = 1'b0;

  pio_irq_servicer #(.TS_W(TS_W), .MASK_VALUE(32'd1), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .irq        (irq),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_level  (evt_level),
    .evt_time   (evt_time),
    .evt_count  (evt_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string detail);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  // ---------------- PIO slave model (mask, edge capture, registered read) ----
  logic       s_cs, s_wn, s_wd0, s_pin;
  logic [1:0] s_addr;
  logic       mask_r = 1'b0, cap_r = 1'b0, pin_prev = 1'b0;
  logic [31:0] rnd;

  always begin
    @(negedge clk);
    s_cs = chipselect; s_wn = write_n; s_addr = address; s_wd0 = writedata[0]; s_pin = pin;
    @(posedge clk);
    #1;
    if (s_cs && !s_wn && s_addr == 2'd2) mask_r = s_wd0;
    if (s_cs && !s_wn && s_addr == 2'd3) cap_r = 1'b0;
    if (s_pin && !pin_prev) cap_r = 1'b1;
    pin_prev = s_pin;
    rnd = $urandom();
    if (s_cs && s_wn && s_addr == 2'd0) readdata = {rnd[31:1], s_pin};
    else readdata = rnd;
    irq = cap_r & mask_r;
  end

  // ---------------- reference model: protocol timeline per accepted irq -----
  typedef struct {
    int         cyc;
    logic [1:0] addr;
    logic       wr;
    logic       wd0;
  } bus_t;

  typedef struct {
    int              vcyc;
    logic            level;
    logic [TS_W-1:0] tm;
    logic [CNT_W-1:0] cnt_after;
  } evt_t;

  bus_t bus_q[$];
  evt_t evt_q[$];

  bit               in_reset = 1'b1;
  int               k0 = 0;
  int               idle_from = 0;
  bit               busy = 1'b0;
  int               acc_cyc = 0;
  logic [CNT_W-1:0] count_m = '0;
  logic [CNT_W-1:0] cnt_after_m = '0;

  always @(negedge clk) begin
    if (reset) begin
      in_reset = 1'b1;
      busy     = 1'b0;
      count_m  = '0;
      evt_q.delete();
      while (bus_q.size() > 0 && bus_q[$].cyc > cyc) void'(bus_q.pop_back());
    end else begin
      if (in_reset) begin
        in_reset  = 1'b0;
        k0        = cyc;
        bus_q.push_back('{cyc + 1, 2'd2, 1'b1, 1'b1});
        idle_from = cyc + 2;
      end
      if (busy) begin
        if (cyc == acc_cyc + 2)
          evt_q.push_back('{acc_cyc + 4, pin, TS_W'(acc_cyc - k0), cnt_after_m});
        if (cyc >= acc_cyc + 4 && evt_ready) begin
          count_m   = cnt_after_m;
          busy      = 1'b0;
          idle_from = cyc + 1;
        end
      end else if (cyc >= idle_from && enable && irq) begin
        busy        = 1'b1;
        acc_cyc     = cyc;
        cnt_after_m = (count_m == '1) ? count_m : count_m + CNT_W'(1);
        bus_q.push_back('{cyc + 1, 2'd3, 1'b1, 1'b0});
        bus_q.push_back('{cyc + 2, 2'd0, 1'b0, 1'b0});
      end
    end
  end

  // ---------------- monitor / scoreboard ------------------------------------
  bit               prev_valid = 1'b0, prev_hs = 1'b0, cnt_pend = 1'b0;
  logic [CNT_W-1:0] cnt_exp = '0;
  bus_t             b;
  evt_t             e;

  always begin
    @(negedge clk);
    #1;
    if (chipselect) begin
      if (bus_q.size() == 0) begin
        flag("bus_unexpected", $sformatf("got access addr=%0d write_n=%0b, expected none", address, write_n));
      end else begin
        b = bus_q.pop_front();
        check("bus_cycle", cyc, b.cyc);
        check("bus_addr", 32'(address), 32'(b.addr));
        check("bus_write", 32'(!write_n), 32'(b.wr));
        if (b.wr) check("bus_wdata", writedata, {31'b0, b.wd0});
      end
    end
    if (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
      flag("bus_missing", $sformatf("got no access, expected addr=%0d in cycle %0d", bus_q[0].addr, bus_q[0].cyc));
      void'(bus_q.pop_front());
    end

    if (reset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      cnt_pend   = 1'b0;
    end else begin
      if (cnt_pend) begin
        check("evt_count", 32'(evt_count), 32'(cnt_exp));
        cnt_pend = 1'b0;
      end
      if (evt_valid) begin
        if (evt_q.size() == 0) begin
          flag("evt_unexpected", "got evt_valid=1, expected no event");
        end else begin
          e = evt_q[0];
          if (!prev_valid || prev_hs) check("evt_first_cycle", cyc, e.vcyc);
          check("evt_level", 32'(evt_level), 32'(e.level));
          check("evt_time", 32'(evt_time), 32'(e.tm));
          if (evt_ready) begin
            void'(evt_q.pop_front());
            cnt_pend = 1'b1;
            cnt_exp  = e.cnt_after;
          end
        end
      end else if (evt_q.size() > 0 && cyc >= evt_q[0].vcyc) begin
        flag("evt_missing", $sformatf("got evt_valid=0, expected event from cycle %0d", evt_q[0].vcyc));
        void'(evt_q.pop_front());
      end
      prev_valid = evt_valid;
      prev_hs    = evt_valid && evt_ready;
    end
  end

  // ---------------- directed + random stimulus ------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cs"}, 32'(chipselect), 32'd0);
    check({tag, "_write_n"}, 32'(write_n), 32'd1);
    check({tag, "_addr"}, 32'(address), 32'd0);
    check({tag, "_wdata"}, writedata, 32'd0);
    check({tag, "_valid"}, 32'(evt_valid), 32'd0);
    check({tag, "_level"}, 32'(evt_level), 32'd0);
    check({tag, "_time"}, 32'(evt_time), 32'd0);
    check({tag, "_count"}, 32'(evt_count), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!evt_valid && n < budget) begin
      tick();
      n++;
    end
    if (!evt_valid) flag("wait_valid_timeout", "got evt_valid=0, expected 1 within budget");
  endtask

  task automatic wait_count(input logic [CNT_W-1:0] target, input int budget);
    int n = 0;
    while (evt_count != target && n < budget) begin
      tick();
      n++;
    end
    check("evt_count_target", 32'(evt_count), 32'(target));
  endtask

  initial begin
    // Reset, then INIT mask write (scoreboard) and reset values.
    repeat (3) tick();
    reset = 1'b0;
    check_reset_values("reset");
    enable = 1'b1;

    // Single event accepted at timestamp 0x0010, pin high.
    repeat (15) tick();
    pin = 1'b1;
    wait_valid(30);
    check("first_evt_time", 32'(evt_time), 32'h10);
    check("first_evt_level", 32'(evt_level), 32'd1);
    wait_count(1, 20);
    pin = 1'b0;
    tick();

    // Back-pressure: event held while pin toggles; coalesced edge follows.
    evt_ready = 1'b0;
    pin = 1'b1;
    wait_valid(30);
    for (int i = 0; i < 10; i++) begin
      tick();
      pin = ~pin;
    end
    check("bp_valid_held", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    pin = 1'b0;
    wait_count(3, 50);

    // enable low with irq pending: nothing happens until enable rises.
    enable = 1'b0;
    tick();
    pin = 1'b1;
    repeat (20) tick();
    check("enable_low_irq", 32'(irq), 32'd1);
    check("enable_low_count", 32'(evt_count), 32'd3);
    enable = 1'b1;
    wait_count(4, 30);
    pin = 1'b0;

    // Randomized traffic.
    repeat (400) begin
      tick();
      pin       = ($urandom_range(0, 3) == 0) ? ~pin : pin;
      enable    = ($urandom_range(0, 7) != 0);
      evt_ready = ($urandom_range(0, 3) != 0);
    end
    enable    = 1'b1;
    evt_ready = 1'b1;
    repeat (20) tick();

    // Timestamp wrap: irq accepted exactly at 0xFFFF.
    reset = 1'b1;
    enable = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    pin = 1'b0;
    tick();
    pin = 1'b1;
    tick();
    repeat (65533) tick();
    enable = 1'b1;
    wait_valid(20);
    check("wrap_evt_time", 32'(evt_time), 32'hFFFF);
    wait_count(1, 20);
    repeat (3) tick();
    pin = 1'b0;
    tick();

    // Reset during RD_ISSUE abandons the sequence and re-arms the mask.
    pin = 1'b1;
    begin
      int n = 0;
      while (!(chipselect && write_n) && n < 30) begin
        tick();
        n++;
      end
      if (!(chipselect && write_n)) flag("wait_rd_issue_timeout", "got no read cycle, expected one");
    end
    reset = 1'b1;
    tick();
    check_reset_values("midseq_reset");
    reset = 1'b0;
    tick();
    check("rearm_cs", 32'(chipselect), 32'd1);
    check("rearm_write_n", 32'(write_n), 32'd0);
    check("rearm_addr", 32'(address), 32'd2);
    check("rearm_wdata", writedata, 32'd1);
    tick();
    check("rearm_count", 32'(evt_count), 32'd0);
    enable = 1'b0;
    repeat (10) tick();
    check("drain_bus_queue", bus_q.size(), 32'd0);
    check("drain_evt_queue", evt_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_irq_servicer.md
Name: pio_irq_servicer

Overview:
- Avalon-MM initiator for the single-bit edge-capturing input PIO slave (registers: 0 = data, 2 = irq mask, 3 = edge capture).
- After reset it arms the slave's irq mask. On each irq it clears the edge capture, reads the pin level and emits a timestamped event on a valid/ready stream.
- Sits between the PIO slave and the acquisition/control logic, so that logic no longer polls the PIO over the bus.

Parameters:
- TS_W, 16, width of the free-running timestamp counter and evt_time.
- MASK_VALUE, 1, value written to the irq mask register during init (bit 0 only is meaningful).
- CNT_W, 16, width of the saturating serviced-event counter.

Ports:
- clk  in  1  system clock; all logic rises on posedge clk.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when 0, IDLE does not accept irq; an in-progress sequence always completes.
- irq  in  1  level interrupt from the PIO slave.
- address  out  2  Avalon address to the slave.
- chipselect  out  1  Avalon chipselect.
- write_n  out  1  Avalon active-low write strobe.
- writedata  out  32  Avalon write data.
- readdata  in  32  Avalon read data; registered in the slave, so read latency is 1 and there is no waitrequest.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_level  out  1  pin level read from data register bit 0.
- evt_time  out  TS_W  timestamp latched on the cycle irq was accepted.
- evt_count  out  CNT_W  number of events accepted by the consumer; saturates at all-ones.

Behaviour:
- Reset, applied on the clock edge while reset=1:
  - state <= INIT, address <= 0, chipselect <= 0, write_n <= 1, writedata <= 0.
  - evt_valid <= 0, evt_level <= 0, evt_time <= 0, evt_count <= 0, timestamp <= 0.
  - A reset mid-sequence abandons the sequence without completing it; INIT re-arms the mask.
- Timestamp: increments every cycle and wraps at 2^TS_W-1 -> 0.
- All bus outputs are registered. Each state below describes the bus outputs during that state.
- States:
  - INIT: cs=1, write_n=0, address=2, writedata=MASK_VALUE. Lasts one cycle, then -> IDLE.
  - IDLE: cs=0, write_n=1, address=0.
    - If irq=1 and enable=1: latch timestamp into evt_time, then -> CLR.
  - CLR: cs=1, write_n=0, address=3, writedata=0. One cycle, then -> RD_ISSUE.
    - Clear happens before the read, so an edge arriving after the clear is re-captured and raises a new irq, not lost.
  - RD_ISSUE: cs=1, write_n=1, address=0. One cycle, then -> RD_CAP.
  - RD_CAP: cs=0, address=0. Sample evt_level <= readdata[0], then -> OUT.
  - OUT: evt_valid=1; evt_level and evt_time are held stable.
    - On evt_valid & evt_ready: evt_valid <= 0, increment evt_count if it is not all-ones, then -> IDLE.
- Latency: with irq accepted in cycle T:
  - CLR in T+1, RD_ISSUE in T+2, RD_CAP in T+3.
  - evt_valid first high in T+4.
  - With evt_ready held at 1, the next irq can be accepted in T+5.
- Back-pressure: while in OUT the block ignores irq. Further edges coalesce in the slave's capture bit and are serviced after the event is accepted.
- The irq seen in the RD_ISSUE and RD_CAP cycles is ignored; only IDLE samples irq.
- enable=0 during OUT: the event is still delivered; the block then waits in IDLE.
- writedata bits 31:1 are always 0.

Decomposition:
- Shared package pio_pkg holds:
  - register address constants PIO_ADDR_DATA=0, PIO_ADDR_MASK=2, PIO_ADDR_EDGE=3;
  - the state enum (INIT, IDLE, CLR, RD_ISSUE, RD_CAP, OUT).
- No sub-module. The timestamp counter and the FSM stay inline.

Test Plan:
- Reset then release -> exactly one cycle with cs=1, write_n=0, address=2, writedata=1; then IDLE with cs=0, write_n=1.
- irq asserted in cycle T with timestamp=0x0010, readdata[0]=1 in T+3, evt_ready=1 -> CLR write to address 3 with data 0 in T+1; read of address 0 in T+2; evt_valid in T+4 with evt_level=1, evt_time=0x0010; evt_count=1.
- evt_ready=0 for 10 cycles, irq toggling meanwhile -> evt_valid, evt_level and evt_time held; no bus activity; after evt_ready=1 the next irq is serviced, giving evt_count=2.
- Preload the timestamp near 0xFFFF, with irq accepted at 0xFFFF -> evt_time=0xFFFF; the counter then reads 0x0000.
- enable=0 with irq=1 for 20 cycles -> no CLR or read; raise enable -> sequence starts the next cycle.
- reset asserted during RD_ISSUE -> outputs take reset values the next cycle; the INIT mask write is reissued and evt_count=0.
